// File: rtl/jump_sequencer.sv
// Jump-game sequencer: charge, flight animation, landing judgement, scoring and lives.
// Optional build macro PERFECT_BONUS_EN: exact-centre landings score 3 and pulse perfect.
module jump_sequencer #(
    parameter int unsigned HALF_WIDTH   = 4,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned RESULT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       charge_active,
    input  logic       charge_done,
    input  logic [7:0] jump_dist,
    input  logic [7:0] target_dist,
    input  logic       tick,
    output logic [7:0] bottle_pos,
    output logic [2:0] state,
    output logic       landed,
    output logic       fell,
    output logic       new_target_req,
    output logic       perfect,
    output logic [11:0] score,
    output logic [2:0] lives_left,
    output logic       game_over
);

    localparam int unsigned SCORE_W   = 12;
    localparam int unsigned SCORE_MAX = 4095;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHARGE = 3'd1,
        S_FLIGHT = 3'd2,
        S_JUDGE  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t             state_r, state_d;
    logic [7:0]         dist_r, dist_d;
    logic [7:0]         bottle_r, bottle_d;
    logic [SCORE_W-1:0] score_r, score_d;
    logic [2:0]         lives_r, lives_d;
    logic [CNT_W-1:0]   cnt_r, cnt_d;
    logic               landed_r, landed_d;
    logic               fell_r, fell_d;
    logic               ntr_r, ntr_d;
    logic               perfect_r, perfect_d;
    logic               over_r, over_d;

    logic signed [8:0]  diff;
    logic [8:0]         abs_diff;
    logic               hit;
    logic [1:0]         inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    // Landing judgement: signed distance error and saturating score update.
    always_comb begin
        diff     = $signed({1'b0, dist_r}) - $signed({1'b0, target_dist});
        abs_diff = diff[8] ? 9'(-diff) : 9'(diff);
        hit      = (abs_diff <= 9'(HALF_WIDTH));
`ifdef PERFECT_BONUS_EN
        inc      = (diff == 9'sd0) ? 2'd3 : 2'd1;
`else
        inc      = 2'd1;
`endif
        score_sum = (SCORE_W+1)'(score_r) + (SCORE_W+1)'(inc);
        score_sat = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                          : score_sum[SCORE_W-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_r;
        dist_d    = dist_r;
        bottle_d  = bottle_r;
        score_d   = score_r;
        lives_d   = lives_r;
        cnt_d     = cnt_r;
        landed_d  = 1'b0;
        fell_d    = 1'b0;
        ntr_d     = 1'b0;
        perfect_d = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (charge_done) begin
                    dist_d   = jump_dist;
                    bottle_d = 8'd0;
                    state_d  = S_FLIGHT;
                end else if (charge_active) begin
                    state_d = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (charge_done) begin
                    dist_d   = jump_dist;
                    bottle_d = 8'd0;
                    state_d  = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (bottle_r == dist_r) begin
                    state_d = S_JUDGE;
                end else if (tick) begin
                    bottle_d = bottle_r + 8'd1;
                end
            end
            S_JUDGE: begin
                cnt_d = '0;
                if (hit) begin
                    score_d  = score_sat;
                    landed_d = 1'b1;
                    ntr_d    = 1'b1;
`ifdef PERFECT_BONUS_EN
                    perfect_d = (diff == 9'sd0);
`endif
                    state_d  = S_RESULT;
                end else begin
                    fell_d  = 1'b1;
                    lives_d = lives_r - 3'd1;
                    state_d = (lives_r == 3'd1) ? S_OVER : S_RESULT;
                end
            end
            S_RESULT: begin
                if (tick) begin
                    if (cnt_r == CNT_W'(RESULT_TICKS - 1)) begin
                        cnt_d    = '0;
                        bottle_d = 8'd0;
                        state_d  = S_IDLE;
                    end else begin
                        cnt_d = cnt_r + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (charge_done) begin
                    score_d  = '0;
                    lives_d  = 3'(LIVES);
                    bottle_d = 8'd0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            dist_r    <= 8'd0;
            bottle_r  <= 8'd0;
            score_r   <= '0;
            lives_r   <= 3'(LIVES);
            cnt_r     <= '0;
            landed_r  <= 1'b0;
            fell_r    <= 1'b0;
            ntr_r     <= 1'b0;
            perfect_r <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            state_r   <= state_d;
            dist_r    <= dist_d;
            bottle_r  <= bottle_d;
            score_r   <= score_d;
            lives_r   <= lives_d;
            cnt_r     <= cnt_d;
            landed_r  <= landed_d;
            fell_r    <= fell_d;
            ntr_r     <= ntr_d;
            perfect_r <= perfect_d;
            over_r    <= over_d;
        end
    end

    assign state          = state_r;
    assign bottle_pos     = bottle_r;
    assign score          = score_r;
    assign lives_left     = lives_r;
    assign landed         = landed_r;
    assign fell           = fell_r;
    assign new_target_req = ntr_r;
    assign perfect        = perfect_r;
    assign game_over      = over_r;

endmodule

// File: tb/tb_jump_sequencer.sv
// Self-checking bench for jump_sequencer: directed vector table plus multi-cycle sequences.
module tb_jump_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_CHARGE = 3'd1, S_FLIGHT = 3'd2,
                           S_JUDGE = 3'd3, S_RESULT = 3'd4, S_OVER = 3'd5;
`ifdef PERFECT_BONUS_EN
    localparam bit PB = 1'b1;
`else
    localparam bit PB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        charge_active, charge_done, tick;
    logic [7:0]  jump_dist, target_dist;
    logic [7:0]  bottle_pos;
    logic [2:0]  state;
    logic        landed, fell, new_target_req, perfect, game_over;
    logic [11:0] score;
    logic [2:0]  lives_left;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;
    int exp_lives = 3;

    jump_sequencer #(.HALF_WIDTH(4), .LIVES(3), .RESULT_TICKS(8)) dut (
        .clk(clk), .rst_n(rst_n), .charge_active(charge_active), .charge_done(charge_done),
        .jump_dist(jump_dist), .target_dist(target_dist), .tick(tick),
        .bottle_pos(bottle_pos), .state(state), .landed(landed), .fell(fell),
        .new_target_req(new_target_req), .perfect(perfect), .score(score),
        .lives_left(lives_left), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] jd;
        logic [7:0] td;
        logic       hit;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int n = 0;
        while (state !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(state), int'(s));
    endtask

    // One complete jump from IDLE; updates the score/lives model and checks the outcome.
    task automatic do_jump(input logic [7:0] jd, input logic [7:0] td, input logic exp_hit,
                           input bit chk, input logic fl_tick);
        int inc;
        @(negedge clk);
        jump_dist = jd; target_dist = td; charge_done = 1'b1;
        @(negedge clk);
        charge_done = 1'b0; tick = fl_tick;
        wait_state(S_JUDGE, 600, "reach_judge");
        @(negedge clk);
        tick = 1'b0;
        if (exp_hit) begin
            inc = (PB && jd == td) ? 3 : 1;
            exp_score = (exp_score + inc > 4095) ? 4095 : exp_score + inc;
        end else begin
            exp_lives--;
        end
        if (chk) begin
            check("landed", int'(landed), int'(exp_hit));
            check("new_target_req", int'(new_target_req), int'(exp_hit));
            check("fell", int'(fell), int'(!exp_hit));
            check("perfect", int'(perfect), int'(PB && exp_hit && jd == td));
            check("score", int'(score), exp_score);
            check("lives_left", int'(lives_left), exp_lives);
            check("state_after_judge", int'(state),
                  (!exp_hit && exp_lives == 0) ? int'(S_OVER) : int'(S_RESULT));
            check("game_over", int'(game_over), int'(exp_lives == 0));
        end
        if (state == S_RESULT) tick = 1'b1;
        @(negedge clk);
        if (chk) begin
            check("pulse_one_cycle", int'({landed, fell, new_target_req, perfect}), 0);
        end
        if (state == S_RESULT) begin
            wait_state(S_IDLE, 40, "result_to_idle");
            if (chk) check("bottle_cleared", int'(bottle_pos), 0);
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_score = 0;
        exp_lives = 3;
    endtask

    initial begin
        bit injected;
        rst_n = 1'b0; charge_active = 1'b0; charge_done = 1'b0; tick = 1'b0;
        jump_dist = 8'd0; target_dist = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_state", int'(state), int'(S_IDLE));
        check("rst_bottle", int'(bottle_pos), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives_left), 3);
        check("rst_pulses", int'({landed, fell, new_target_req, perfect, game_over}), 0);

        // Full jump with charge phase and explicit tick-by-tick flight.
        charge_active = 1'b1;
        repeat (5) @(negedge clk);
        check("charge_state", int'(state), int'(S_CHARGE));
        charge_active = 1'b0;
        @(negedge clk);
        check("charge_hold", int'(state), int'(S_CHARGE));
        jump_dist = 8'd20; target_dist = 8'd22; charge_done = 1'b1;
        @(negedge clk);
        charge_done = 1'b0;
        check("flight_entry", int'(state), int'(S_FLIGHT));
        check("flight_pos0", int'(bottle_pos), 0);
        for (int k = 1; k <= 20; k++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check("flight_pos", int'(bottle_pos), k);
            @(negedge clk);
        end
        wait_state(S_JUDGE, 5, "flight_to_judge");
        @(negedge clk);
        check("seq_landed", int'(landed), 1);
        check("seq_ntr", int'(new_target_req), 1);
        check("seq_score", int'(score), 1);
        for (int k = 1; k <= 8; k++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (k == 7) check("result_hold", int'(state), int'(S_RESULT));
            if (k == 8) check("result_done", int'(state), int'(S_IDLE));
            @(negedge clk);
        end
        check("idle_bottle", int'(bottle_pos), 0);
        exp_score = 1;

        // Landing window boundaries around target 40 and other edges.
        vecs[0] = '{jd: 8'd36,  td: 8'd40,  hit: 1'b1};
        vecs[1] = '{jd: 8'd44,  td: 8'd40,  hit: 1'b1};
        vecs[2] = '{jd: 8'd35,  td: 8'd40,  hit: 1'b0};
        vecs[3] = '{jd: 8'd45,  td: 8'd40,  hit: 1'b0};
        vecs[4] = '{jd: 8'd40,  td: 8'd40,  hit: 1'b1};
        vecs[5] = '{jd: 8'd0,   td: 8'd4,   hit: 1'b1};
        vecs[6] = '{jd: 8'd4,   td: 8'd0,   hit: 1'b1};
        vecs[7] = '{jd: 8'd255, td: 8'd250, hit: 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i == 7) do_reset();
            do_jump(vecs[i].jd, vecs[i].td, vecs[i].hit, 1'b1, 1'b1);
        end

        // Zero distance lands without any tick.
        do_jump(8'd0, 8'd0, 1'b1, 1'b1, 1'b0);

        // Mid-flight reset; charge_done during flight must not relatch.
        @(negedge clk);
        jump_dist = 8'd50; target_dist = 8'd50; charge_done = 1'b1;
        @(negedge clk);
        charge_done = 1'b0; tick = 1'b1; injected = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bottle_pos == 8'd7) break;
            if (bottle_pos == 8'd2 && !injected) begin
                charge_done = 1'b1; jump_dist = 8'd3; injected = 1'b1;
            end else begin
                charge_done = 1'b0;
            end
            @(negedge clk);
        end
        charge_done = 1'b0;
        check("flight_no_relatch", int'(state), int'(S_FLIGHT));
        check("flight_pos7", int'(bottle_pos), 7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; tick = 1'b0;
        check("midrst_state", int'(state), int'(S_IDLE));
        check("midrst_bottle", int'(bottle_pos), 0);
        check("midrst_score", int'(score), 0);
        check("midrst_lives", int'(lives_left), 3);
        exp_score = 0; exp_lives = 3;

        // Game over after three misses, OVER ignores inputs, restart on charge_done.
        do_jump(8'd10, 8'd12, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_jump(8'd10, 8'd30, 1'b0, 1'b1, 1'b1);
        tick = 1'b1; charge_active = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0; charge_active = 1'b0;
        check("over_hold_state", int'(state), int'(S_OVER));
        check("over_hold_score", int'(score), 1);
        charge_done = 1'b1;
        @(negedge clk);
        charge_done = 1'b0;
        check("restart_state", int'(state), int'(S_IDLE));
        check("restart_score", int'(score), 0);
        check("restart_lives", int'(lives_left), 3);
        check("restart_game_over", int'(game_over), 0);
        exp_score = 0; exp_lives = 3;

        // Exact hit from score 100, then saturation at 4095.
        while (exp_score < 100) do_jump(8'd1, 8'd0, 1'b1, 1'b0, 1'b1);
        check("preload_100", int'(score), 100);
        do_jump(8'd40, 8'd40, 1'b1, 1'b1, 1'b1);
        check("exact_hit_score", int'(score), PB ? 103 : 101);
        while (exp_score < 4094) do_jump(8'd1, 8'd0, 1'b1, 1'b0, 1'b1);
        check("preload_4094", int'(score), 4094);
        do_jump(8'd1, 8'd0, 1'b1, 1'b1, 1'b1);
        check("sat_first", int'(score), 4095);
        do_jump(8'd1, 8'd0, 1'b1, 1'b1, 1'b1);
        check("sat_hold", int'(score), 4095);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
